dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitrates the single-port byte-wide data memory (14-bit address, 8-bit data, 1-cycle read latency) between two requesters: the pipeline memory stage (P) and a host/loader port (H) used for program/data loading and debug.
- P has priority; a starvation counter guarantees H forward progress.
- H can lock the memory for bursts.
- Sits between the memory-stage datapath and the data RAM. Drives the RAM command and returns read data with a per-requester valid.

Parameters:
ADDR_W, 14, memory address width
DATA_W, 8, memory data width
STARVE_LIMIT, 4, consecutive denied H cycles before H is forced one grant (legal range 1..15)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
p_req  in  1  pipeline access request, held until granted
p_we  in  1  pipeline write (1) / read (0)
p_addr  in  ADDR_W  pipeline address
p_wdata  in  DATA_W  pipeline write data
p_gnt  out  1  pipeline access accepted this cycle (combinational)
p_stall  out  1  p_req & !p_gnt, to pipeline hazard logic
p_rvalid  out  1  pipeline read data valid (registered)
p_rdata  out  DATA_W  pipeline read data
h_req  in  1  host request
h_we  in  1  host write/read
h_lock  in  1  host requests exclusive ownership while h_req stays high
h_addr  in  ADDR_W  host address
h_wdata  in  DATA_W  host write data
h_gnt  out  1  host access accepted this cycle (combinational)
h_rvalid  out  1  host read data valid (registered)
h_rdata  out  DATA_W  host read data
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read command

Behaviour:
- Reset and clocking: one clock domain; reset is synchronous and active-high. Reset sets state=P_PRIO, starve_cnt=0, p_rvalid=h_rvalid=0, and clears the read-owner flags.
  - While reset is high: p_gnt=h_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Transfer: a transfer occurs when req&gnt in the same cycle. At most one grant per cycle; gnt never asserts without req.
- Memory command: the granted port's addr/we/wdata drive mem_* combinationally in that cycle. With no grant: mem_we=0, mem_addr/mem_wdata=0.
- Read return: a granted read in cycle T gives rvalid=1 to the issuing port only, in cycle T+1, with rdata=mem_rdata. rdata is 0 when rvalid=0. Writes produce no rvalid.
- Back-to-back: accesses may be granted every cycle, including read in T followed by a different port's access in T+1. The return is steered by the owner flag registered at T.
- FSM states:
  - P_PRIO:
    - If p_req: grant P. If h_req is also high, starve_cnt++.
    - Else if h_req: grant H, starve_cnt=0. If h_lock, go to H_LOCKED.
    - When h_req is high and starve_cnt reaches STARVE_LIMIT-1 while being denied, go to H_FORCE.
    - h_req low clears starve_cnt.
  - H_FORCE:
    - Grant H unconditionally if h_req, with P stalled. starve_cnt=0.
    - Next state is H_LOCKED if h_lock, else P_PRIO.
    - If h_req dropped, grant P if requesting, return to P_PRIO, starve_cnt=0.
  - H_LOCKED:
    - Grant H every cycle h_req=1; P is stalled.
    - Exit to P_PRIO in the first cycle h_req=0 or h_lock=0. In that exit cycle, arbitration follows P_PRIO rules.
- Counter: starve_cnt is 4 bits wide and saturates; it never wraps.
- Reset mid-operation: a pending rvalid is discarded and the lock is released. No spurious rvalid in the cycle after reset deasserts.

Decomposition:
- Package dmem_pkg:
  - ADDR_W/DATA_W defaults.
  - typedef enum logic [1:0] {P_PRIO, H_FORCE, H_LOCKED} arb_state_t.
  - typedef enum logic [1:0] {OWN_NONE, OWN_P, OWN_H} rd_owner_t.
- One sub-module, dmem_rd_return: registers owner and valid, and steers mem_rdata to p_rdata/h_rdata. Arbitration FSM and command mux stay in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset 3 cycles with p_req=h_req=1.
  - Response: p_gnt=h_gnt=0, mem_we=0. After release, the first cycle grants P.
- P write then read:
  - Stimulus: P write addr 0x0012 data 0xA5, then P read 0x0012.
  - Response: read gives p_rvalid=1 one cycle after the read grant with p_rdata=0xA5. h_rvalid stays 0.
- Starvation:
  - Stimulus: STARVE_LIMIT=4; p_req and h_req both held high continuously, host reads 0x0100.
  - Response: P granted 4 cycles, H granted on the 5th (p_stall=1 that cycle), then P again. The pattern repeats.
- Lock burst:
  - Stimulus: h_lock=1, h_req writes 0x00..0x07 to addr 0x0200..0x0207 while p_req=1.
  - Response: 8 consecutive h_gnt, p_stall=1 throughout. P is granted in the cycle h_req drops.
- Interleaved returns:
  - Stimulus: H read 0x0200 at T, P read 0x0012 at T+1.
  - Response: h_rvalid/h_rdata=0x00 at T+1, p_rvalid/p_rdata=0xA5 at T+2. The valids never overlap.
- Reset mid-read:
  - Stimulus: assert reset in the cycle after a granted P read.
  - Response: p_rvalid=0 and state returns to P_PRIO. A held lock is released.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {P_PRIO, H_FORCE, H_LOCKED} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_P, OWN_H} rd_owner_t;

    // Saturating increment so the starvation counter never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_rd_return.sv
// Read-return steering: remembers who issued last cycle's read and routes
// the RAM's one-cycle-late data to that requester only.
module dmem_rd_return
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_rd,
    input  logic              h_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata
);

    rd_owner_t owner;

    // Capture the owner of the read issued this cycle (at most one grant).
    always_ff @(posedge clk) begin
        if (reset)     owner <= OWN_NONE;
        else if (p_rd) owner <= OWN_P;
        else if (h_rd) owner <= OWN_H;
        else           owner <= OWN_NONE;
    end

    // Reset also masks a return already in flight so it is discarded.
    assign p_rvalid = (owner == OWN_P) && !reset;
    assign h_rvalid = (owner == OWN_H) && !reset;
    assign p_rdata  = p_rvalid ? mem_rdata : '0;
    assign h_rdata  = h_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: pipeline (P) has priority, host (H) gets a
// forced slot after STARVE_LIMIT denials and may lock the RAM for bursts.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic              h_lock,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter value at which one more denial triggers the forced host slot.
    localparam logic [CNT_W-1:0] FORCE_AT = CNT_W'(STARVE_LIMIT - 1);

    arb_state_t       state, state_nx;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_nx;
    logic             prio_rules;

    // Arbitration state and starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= P_PRIO;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_cnt_nx;
        end
    end

    // Grant decision and next state; leaving H_LOCKED falls through to P_PRIO rules.
    always_comb begin
        state_nx      = state;
        starve_cnt_nx = starve_cnt;
        p_gnt         = 1'b0;
        h_gnt         = 1'b0;
        prio_rules    = 1'b0;
        case (state)
            H_FORCE: begin
                starve_cnt_nx = '0;
                if (h_req) begin
                    h_gnt    = 1'b1;
                    state_nx = h_lock ? H_LOCKED : P_PRIO;
                end else begin
                    p_gnt    = p_req;
                    state_nx = P_PRIO;
                end
            end
            H_LOCKED: begin
                if (h_req && h_lock) begin
                    h_gnt         = 1'b1;
                    starve_cnt_nx = '0;
                end else begin
                    prio_rules = 1'b1;
                end
            end
            default: prio_rules = 1'b1;
        endcase
        if (prio_rules) begin
            state_nx = P_PRIO;
            if (p_req) begin
                p_gnt = 1'b1;
                if (h_req) begin
                    starve_cnt_nx = sat_inc(starve_cnt);
                    if (starve_cnt >= FORCE_AT) state_nx = H_FORCE;
                end else begin
                    starve_cnt_nx = '0;
                end
            end else if (h_req) begin
                h_gnt         = 1'b1;
                starve_cnt_nx = '0;
                if (h_lock) state_nx = H_LOCKED;
            end else begin
                starve_cnt_nx = '0;
            end
        end
        if (reset) begin
            p_gnt = 1'b0;
            h_gnt = 1'b0;
        end
    end

    // RAM command follows whichever port won this cycle; idle bus is all zero.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (h_gnt) begin
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
            mem_we    = h_we;
        end else if (p_gnt) begin
            mem_addr  = p_addr;
            mem_wdata = p_wdata;
            mem_we    = p_we;
        end
    end

    assign p_stall = p_req & ~p_gnt;

    dmem_rd_return #(.DATA_W(DATA_W)) u_rd_return (
        .clk       (clk),
        .reset     (reset),
        .p_rd      (p_gnt & ~p_we),
        .h_rd      (h_gnt & ~h_we),
        .mem_rdata (mem_rdata),
        .p_rvalid  (p_rvalid),
        .p_rdata   (p_rdata),
        .h_rvalid  (h_rvalid),
        .h_rdata   (h_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural arbitration model plus read-return scoreboard.
module tb_dmem_arbiter;

    localparam int AW  = 14;
    localparam int DW  = 8;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          p_req = 1'b0, p_we = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0;
    logic          h_req = 1'b0, h_we = 1'b0, h_lock = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic          p_gnt, p_stall, p_rvalid, h_gnt, h_rvalid, mem_we;
    logic [DW-1:0] p_rdata, h_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // RAM being arbitrated (environment) and the model's own copy of memory.
    logic [DW-1:0] ram  [0:(1<<AW)-1];
    logic [DW-1:0] mmem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
        cyc <= cyc + 1;
    end

    typedef struct {logic [DW-1:0] data; int due;} rd_t;
    rd_t qp[$];
    rd_t qh[$];

    // Reference model: host wins when locked, when P is idle, or after LIM denials.
    int denied = 0;
    bit locked = 0;
    always @(negedge clk) begin
        bit hw, pw, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (reset) begin
            chk("rst_p_gnt", p_gnt, 0);
            chk("rst_h_gnt", h_gnt, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_p_stall", p_stall, p_req);
            denied = 0;
            locked = 0;
        end else begin
            hw = h_req && ((locked && h_lock) || !p_req || denied >= LIM);
            pw = p_req && !hw;
            ea = '0; ed = '0; ew = 0;
            if (hw) begin ea = h_addr; ed = h_wdata; ew = h_we; end
            else if (pw) begin ea = p_addr; ed = p_wdata; ew = p_we; end
            chk("p_gnt", p_gnt, pw);
            chk("h_gnt", h_gnt, hw);
            chk("p_stall", p_stall, p_req && !pw);
            chk("mem_we", mem_we, ew);
            chk("mem_addr", mem_addr, ea);
            chk("mem_wdata", mem_wdata, ed);
            if ((hw || pw) && ew) mmem[ea] = ed;
            if (hw && !h_we) qh.push_back('{data: mmem[ea], due: cyc + 1});
            if (pw && !p_we) qp.push_back('{data: mmem[ea], due: cyc + 1});
            if (hw || !h_req) denied = 0;
            else if (denied < 15) denied++;
            locked = hw && h_lock;
        end
    end

    // Monitor: pops the expected return whenever a port presents rvalid.
    always @(negedge clk) begin
        rd_t e;
        if (reset) begin
            chk("rst_p_rvalid", p_rvalid, 0);
            chk("rst_h_rvalid", h_rvalid, 0);
            qp.delete();
            qh.delete();
        end else begin
            chk("rvalid_overlap", p_rvalid && h_rvalid, 0);
            if (p_rvalid) begin
                if (qp.size() == 0) chk("p_rvalid_spurious", 1, 0);
                else begin
                    e = qp.pop_front();
                    chk("p_rvalid_cycle", cyc, e.due);
                    chk("p_rdata", p_rdata, e.data);
                end
            end else begin
                chk("p_rdata_idle", p_rdata, 0);
                if (qp.size() != 0 && qp[0].due <= cyc) begin
                    chk("p_rvalid_missing", 0, 1);
                    void'(qp.pop_front());
                end
            end
            if (h_rvalid) begin
                if (qh.size() == 0) chk("h_rvalid_spurious", 1, 0);
                else begin
                    e = qh.pop_front();
                    chk("h_rvalid_cycle", cyc, e.due);
                    chk("h_rdata", h_rdata, e.data);
                end
            end else begin
                chk("h_rdata_idle", h_rdata, 0);
                if (qh.size() != 0 && qh[0].due <= cyc) begin
                    chk("h_rvalid_missing", 0, 1);
                    void'(qh.pop_front());
                end
            end
        end
    end

    task automatic p_acc(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit last);
        int n = 0;
        p_req = 1; p_we = we; p_addr = a; p_wdata = d;
        do begin @(negedge clk); n++; end while (!p_gnt && n < 64);
        if (!p_gnt) chk("p_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        if (last) p_req = 0;
    endtask

    task automatic h_acc(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit lk, input bit last);
        int n = 0;
        h_req = 1; h_we = we; h_addr = a; h_wdata = d; h_lock = lk;
        do begin @(negedge clk); n++; end while (!h_gnt && n < 64);
        if (!h_gnt) chk("h_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        if (last) begin h_req = 0; h_lock = 0; end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; mmem[i] = '0; end
        // Reset held with both requesters asking.
        p_req = 1; h_req = 1; h_addr = 14'h0100;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(posedge clk); #1;
        p_req = 0; h_req = 0;
        @(posedge clk); #1;

        // P write then read back.
        p_acc(1, 14'h0012, 8'hA5, 1);
        p_acc(0, 14'h0012, 8'h00, 1);
        repeat (2) @(posedge clk); #1;

        // Starvation: both held high, host reads 0x0100.
        fork
            for (int i = 0; i < 12; i++) p_acc(0, 14'(i), 8'h00, i == 11);
            for (int j = 0; j < 3; j++) h_acc(0, 14'h0100, 8'h00, 0, j == 2);
        join
        repeat (2) @(posedge clk); #1;

        // Locked host burst against a busy pipeline.
        fork
            for (int i = 0; i < 20; i++) p_acc(0, 14'h0012, 8'h00, i == 19);
            for (int j = 0; j < 8; j++) h_acc(1, 14'(14'h0200 + j), 8'(j), 1, j == 7);
        join
        repeat (2) @(posedge clk); #1;

        // Interleaved returns: H read then P read on the next cycle.
        h_acc(0, 14'h0200, 8'h00, 0, 1);
        p_acc(0, 14'h0012, 8'h00, 1);
        repeat (2) @(posedge clk); #1;

        // Reset right after a granted P read.
        p_acc(0, 14'h0012, 8'h00, 1);
        reset = 1;
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1;

        // Reset while the host holds the lock.
        h_req = 1; h_lock = 1; h_we = 0; h_addr = 14'h0200;
        repeat (2) @(posedge clk); #1;
        p_req = 1; p_we = 0; p_addr = 14'h0012;
        @(posedge clk); #1 reset = 1;
        repeat (2) @(posedge clk); #1 reset = 0;
        repeat (3) @(posedge clk); #1;
        p_req = 0; h_req = 0; h_lock = 0;
        @(posedge clk); #1;

        // Random traffic with occasional resets, small address window.
        for (int i = 0; i < 600; i++) begin
            p_req   = $urandom_range(0, 3) != 0;
            p_we    = $urandom_range(0, 1) != 0;
            p_addr  = 14'($urandom_range(0, 15));
            p_wdata = 8'($urandom);
            h_req   = $urandom_range(0, 2) != 0;
            h_we    = $urandom_range(0, 1) != 0;
            h_lock  = $urandom_range(0, 3) == 0;
            h_addr  = 14'($urandom_range(0, 15));
            h_wdata = 8'($urandom);
            reset   = $urandom_range(0, 63) == 0;
            @(posedge clk); #1;
        end
        reset = 0; p_req = 0; h_req = 0; h_lock = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queues_drained", qp.size() + qh.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
